pwm_tone_multi: RTL and testbench
=================================

Name: pwm_tone_multi

Overview:
- Multi-channel successor to the single-channel buzzer PWM tone generator.
- Each channel has its own programmable period and duty, held in shadow registers and applied glitch-free at the period boundary.
- A time-multiplexed mix output lets one buzzer pin play several notes as a round-robin chord.
- Sits between the key-scan/note-lookup logic and the buzzer pins of the piano shield.

Parameters:
- CHANNELS, 4, number of independent tone channels (1..16).
- CNT_W, 32, width of the period/duty counters and registers.
- MIX_SLOT, 1024, clock cycles each enabled channel owns mix_out before rotating (>=2).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset.
- wr_en  in  1  write strobe for wr_ch's shadow registers.
- wr_ch  in  CH_W  target channel; CH_W = max(1, clog2(CHANNELS)).
- wr_period  in  CNT_W  period in clk_in cycles.
- wr_duty  in  CNT_W  high-time in clk_in cycles.
- ch_en  in  CHANNELS  per-channel enable.
- pwm_out  out  CHANNELS  per-channel tone output.
- wrap_pulse  out  CHANNELS  1-cycle pulse per channel at period wrap.
- mix_out  out  1  round-robin mixed tone.

Interface fact: one clock, clk_in; reset rst_n_in is asynchronous and active-low.

Behaviour:
- Reset (async, rst_n_in low): all counters, active/shadow period and duty, pending flags, pwm_out, wrap_pulse, mix_out, slot counter and mix select go to 0. This applies mid-tone too; output drops to 0 on reset assertion.
- Write handling:
  - wr_en=1 loads shadow_period/shadow_duty[wr_ch] and sets pending[wr_ch].
  - wr_ch >= CHANNELS: write ignored.
  - Back-to-back writes: the last write before application wins.
- Per channel, with active period P and duty D:
  - Channel is idle if ch_en=0 or P<2.
  - Idle: counter held at 0, pwm_out low next cycle, no wrap_pulse, pending shadow copied to active on the next clock.
  - Running: counter counts 0..P-1 and wraps to 0.
  - pwm_out is registered: high in the cycle after the counter is < D. So D=0 gives constant low, and D>=P gives constant high (no wrap-induced glitch).
  - At counter==P-1: counter goes to 0, wrap_pulse=1 next cycle. If pending, active takes shadow at the same edge and pending clears, so the new period/duty takes effect from counter value 0. A write in the same cycle as the wrap lands in shadow and applies at the following wrap.
- Enable edges:
  - ch_en rising: counting starts at 0 on the next edge; the first high output appears 1 cycle after enable if D>0.
  - ch_en falling: counter reset to 0 and pwm_out low on the next edge, regardless of position in the period.
- Mix:
  - Slot counter runs 0..MIX_SLOT-1 continuously.
  - On wrap, sel advances to the next channel index (modulo CHANNELS) whose ch_en=1. If sel is the only enabled channel, it stays. If none are enabled, sel holds.
  - mix_out is registered: mix_out = pwm_out[sel] & ch_en[sel], so it is 0 when no channel is enabled.
  - If ch_en[sel] drops mid-slot, mix_out goes to 0 for the remainder of the slot, then rotates.
- Arithmetic: counter compare is unsigned CNT_W; no overflow, since the counter never exceeds P-1.

Test Plan:
- Reset release, ch_en=0 -> all pwm_out, wrap_pulse and mix_out stay 0 for 100 cycles.
- Write ch0 P=10, D=3, ch_en=1 -> pwm_out[0] repeats 3 high / 7 low; wrap_pulse[0] every 10 cycles.
- Ch0 running P=10, D=3; mid-period write P=6, D=6 -> old waveform completes the current period, then pwm_out[0] is constant high with wrap_pulse every 6 cycles.
- Edge cases:
  - D=0 -> constant low.
  - P=1 -> idle, output low, no wrap_pulse.
  - Write wr_ch=5 with CHANNELS=4 -> no channel changes.
- MIX_SLOT=16; ch0 (P=4, D=2) and ch2 (P=8, D=4) enabled, ch1 disabled -> mix_out follows ch0 for 16 cycles, then ch2 for 16, then ch0; ch1 is never selected.
- Assert rst_n_in mid-period with ch1 running -> outputs 0 immediately. After release, ch1 stays idle (active P=0) until rewritten.

Source files
------------

// File: rtl/pwm_tone_multi.sv
// Multi-channel buzzer PWM tone generator with shadowed period/duty per channel
// and a round-robin time-multiplexed mix output for a single buzzer pin.
module pwm_tone_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int MIX_SLOT = 1024,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SLOT_W  = $clog2(MIX_SLOT)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_period,
    input  logic [CNT_W-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] wrap_pulse,
    output logic                mix_out
);

    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CNT_W-1:0]    act_p_q  [CHANNELS];
    logic [CNT_W-1:0]    act_p_d  [CHANNELS];
    logic [CNT_W-1:0]    act_d_q  [CHANNELS];
    logic [CNT_W-1:0]    act_d_d  [CHANNELS];
    logic [CNT_W-1:0]    shd_p_q  [CHANNELS];
    logic [CNT_W-1:0]    shd_p_d  [CHANNELS];
    logic [CNT_W-1:0]    shd_d_q  [CHANNELS];
    logic [CNT_W-1:0]    shd_d_d  [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] wrap_q, wrap_d;
    logic [CHANNELS-1:0] wr_hit, idle, at_wrap, apply;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [CH_W-1:0]     cand;
    logic                found;
    logic                mix_q, mix_d;
    logic                wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIM);

    always_comb begin
        pend_d = pend_q;
        pwm_d  = '0;
        wrap_d = '0;
        wr_hit = '0;
        idle   = '0;
        at_wrap = '0;
        apply  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            act_p_d[i] = act_p_q[i];
            act_d_d[i] = act_d_q[i];
            shd_p_d[i] = shd_p_q[i];
            shd_d_d[i] = shd_d_q[i];

            wr_hit[i]  = wr_ok && (wr_ch == CH_W'(i));
            idle[i]    = !ch_en[i] || (act_p_q[i] < CNT_W'(2));
            at_wrap[i] = cnt_q[i] >= act_p_q[i] - CNT_W'(1);
            // Shadow moves to active only while idle or at the period boundary,
            // so a running waveform never sees a half-applied period/duty pair.
            apply[i]   = pend_q[i] && (idle[i] || at_wrap[i]);

            if (apply[i]) begin
                act_p_d[i] = shd_p_q[i];
                act_d_d[i] = shd_d_q[i];
            end
            if (wr_hit[i]) begin
                shd_p_d[i] = wr_period;
                shd_d_d[i] = wr_duty;
            end
            pend_d[i] = wr_hit[i] || (pend_q[i] && !apply[i]);

            if (idle[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i]  = at_wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                wrap_d[i] = at_wrap[i];
                pwm_d[i]  = cnt_q[i] < act_d_q[i];
            end
        end
    end

    // Slot rotation: search forward from sel; the last candidate is sel itself,
    // so a lone enabled channel keeps the slot and no enabled channel holds sel.
    always_comb begin
        slot_d = slot_q + SLOT_W'(1);
        sel_d  = sel_q;
        found  = 1'b0;
        cand   = '0;
        if (slot_q == SLOT_W'(MIX_SLOT - 1)) begin
            slot_d = '0;
            for (int k = 1; k <= CHANNELS; k++) begin
                cand = CH_W'((int'(sel_q) + k) % CHANNELS);
                if (!found && ch_en[cand]) begin
                    sel_d = cand;
                    found = 1'b1;
                end
            end
        end
        mix_d = pwm_q[sel_q] & ch_en[sel_q];
    end

    // NOTE: the per-channel register arrays are reset explicitly because a
    // released reset must leave every channel idle with period 0 until rewritten.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                act_p_q[i] <= '0;
                act_d_q[i] <= '0;
                shd_p_q[i] <= '0;
                shd_d_q[i] <= '0;
            end
            pend_q <= '0;
            pwm_q  <= '0;
            wrap_q <= '0;
            slot_q <= '0;
            sel_q  <= '0;
            mix_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                act_p_q[i] <= act_p_d[i];
                act_d_q[i] <= act_d_d[i];
                shd_p_q[i] <= shd_p_d[i];
                shd_d_q[i] <= shd_d_d[i];
            end
            pend_q <= pend_d;
            pwm_q  <= pwm_d;
            wrap_q <= wrap_d;
            slot_q <= slot_d;
            sel_q  <= sel_d;
            mix_q  <= mix_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_q;
    assign mix_out    = mix_q;

endmodule

// File: tb/tb_pwm_tone_multi.sv
// Self-checking bench for pwm_tone_multi: directed steps plus random traffic,
// compared cycle by cycle against a behavioural per-channel tone model.
module tb_pwm_tone_multi;

    localparam int CH = 5;
    localparam int CW = 16;
    localparam int MS = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          wr_en;
    logic [2:0]    wr_ch;
    logic [CW-1:0] wr_period;
    logic [CW-1:0] wr_duty;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] wrap_pulse;
    logic          mix_out;

    int checks = 0;
    int errors = 0;

    int m_per [CH];
    int m_dut [CH];
    int m_sp  [CH];
    int m_sd  [CH];
    int m_pos [CH];
    bit m_pend[CH];
    bit m_pwm [CH];
    bit m_wrap[CH];
    int m_sel;
    int m_slot;
    bit m_mix;

    pwm_tone_multi #(.CHANNELS(CH), .CNT_W(CW), .MIX_SLOT(MS)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_period  (wr_period),
        .wr_duty    (wr_duty),
        .ch_en      (ch_en),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .mix_out    (mix_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expd, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_per[c] = 0; m_dut[c] = 0; m_sp[c] = 0; m_sd[c] = 0; m_pos[c] = 0;
            m_pend[c] = 0; m_pwm[c] = 0; m_wrap[c] = 0;
        end
        m_sel = 0; m_slot = 0; m_mix = 0;
    endtask

    // One clock edge of the tone generator, evaluated from the inputs at that edge.
    task automatic model_step();
        bit sel_tone;
        bit found;
        int nxt;
        sel_tone = m_pwm[m_sel] & ch_en[m_sel];
        for (int c = 0; c < CH; c++) begin
            m_wrap[c] = 0;
            if (ch_en[c] && m_per[c] >= 2) begin
                m_pwm[c] = (m_pos[c] < m_dut[c]);
                if (m_pos[c] == m_per[c] - 1) begin
                    m_wrap[c] = 1;
                    m_pos[c]  = 0;
                    if (m_pend[c]) begin
                        m_per[c] = m_sp[c]; m_dut[c] = m_sd[c]; m_pend[c] = 0;
                    end
                end else begin
                    m_pos[c]++;
                end
            end else begin
                m_pwm[c] = 0;
                m_pos[c] = 0;
                if (m_pend[c]) begin
                    m_per[c] = m_sp[c]; m_dut[c] = m_sd[c]; m_pend[c] = 0;
                end
            end
        end
        m_mix = sel_tone;
        if (m_slot == MS - 1) begin
            m_slot = 0;
            found  = 0;
            for (int k = 1; k <= CH; k++) begin
                nxt = (m_sel + k) % CH;
                if (!found && ch_en[nxt]) begin
                    m_sel = nxt;
                    found = 1;
                end
            end
        end else begin
            m_slot++;
        end
        if (wr_en && int'(wr_ch) < CH) begin
            m_sp[wr_ch]   = int'(wr_period);
            m_sd[wr_ch]   = int'(wr_duty);
            m_pend[wr_ch] = 1;
        end
    endtask

    task automatic tick();
        logic [CH-1:0] ep;
        logic [CH-1:0] ew;
        @(posedge clk_in);
        model_step();
        #1;
        for (int c = 0; c < CH; c++) begin
            ep[c] = m_pwm[c];
            ew[c] = m_wrap[c];
        end
        check("pwm_out", 32'(pwm_out), 32'(ep));
        check("wrap_pulse", 32'(wrap_pulse), 32'(ew));
        check("mix_out", 32'(mix_out), 32'(m_mix));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_count(input int n, input int ch, output int highs, output int wraps);
        highs = 0;
        wraps = 0;
        repeat (n) begin
            tick();
            highs += int'(pwm_out[ch]);
            wraps += int'(wrap_pulse[ch]);
        end
    endtask

    task automatic write_ch(input int ch, input int p, input int d);
        wr_en     = 1'b1;
        wr_ch     = 3'(ch);
        wr_period = CW'(p);
        wr_duty   = CW'(d);
        tick();
        wr_en     = 1'b0;
    endtask

    initial begin
        int h;
        int w;
        int idx;
        rst_n_in  = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_period = '0;
        wr_duty   = '0;
        ch_en     = '0;
        model_reset();

        #22;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_wrap", 32'(wrap_pulse), 32'd0);
        check("reset_mix", 32'(mix_out), 32'd0);
        rst_n_in = 1'b1;

        // Idle after reset: nothing may toggle.
        run(100);

        // ch0 P=10 D=3: 3 high / 7 low, one wrap per 10 cycles.
        write_ch(0, 10, 3);
        ch_en = 5'b00001;
        run(5);
        run_count(20, 0, h, w);
        check("ch0_p10_highs", 32'(h), 32'd6);
        check("ch0_p10_wraps", 32'(w), 32'd2);

        // Mid-period rewrite to P=6 D=6: old period finishes, then constant high.
        run(3);
        write_ch(0, 6, 6);
        run(12);
        run_count(12, 0, h, w);
        check("ch0_p6_highs", 32'(h), 32'd12);
        check("ch0_p6_wraps", 32'(w), 32'd2);

        // D=0 on ch3: constant low but still wrapping.
        write_ch(3, 5, 0);
        ch_en = 5'b01001;
        run(3);
        run_count(20, 3, h, w);
        check("ch3_d0_highs", 32'(h), 32'd0);
        check("ch3_d0_wraps", 32'(w), 32'd4);

        // P=1 on ch4: idle.
        write_ch(4, 1, 1);
        ch_en = 5'b11001;
        run(3);
        run_count(20, 4, h, w);
        check("ch4_p1_highs", 32'(h), 32'd0);
        check("ch4_p1_wraps", 32'(w), 32'd0);

        // Out-of-range channel writes must leave every channel untouched.
        write_ch(5, 3, 1);
        write_ch(6, 2, 1);
        write_ch(7, 4, 2);
        run(12);
        run_count(12, 0, h, w);
        check("oor_ch0_highs", 32'(h), 32'd12);
        check("oor_ch0_wraps", 32'(w), 32'd2);
        run_count(12, 4, h, w);
        check("oor_ch4_highs", 32'(h), 32'd0);

        // Mix: ch0 (4/2) and ch2 (8/4) enabled, ch1 disabled.
        ch_en = 5'b00000;
        run(2);
        write_ch(0, 4, 2);
        write_ch(2, 8, 4);
        ch_en = 5'b00101;
        run(80);
        run_count(16, 0, h, w);
        check("mix_ch0_highs", 32'(h), 32'd8);
        run_count(16, 2, h, w);
        check("mix_ch2_highs", 32'(h), 32'd8);

        // Random traffic including out-of-range writes and enable toggles.
        repeat (400) begin
            if ($urandom_range(3) == 0) begin
                wr_en     = 1'b1;
                wr_ch     = 3'($urandom_range(7));
                wr_period = CW'($urandom_range(12));
                wr_duty   = CW'($urandom_range(14));
            end else begin
                wr_en = 1'b0;
            end
            if ($urandom_range(15) == 0) begin
                idx = int'($urandom_range(CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            tick();
        end
        wr_en = 1'b0;

        // Reset mid-tone with ch1 running; afterwards ch1 stays idle until rewritten.
        ch_en = 5'b00000;
        run(2);
        write_ch(1, 7, 3);
        ch_en = 5'b00010;
        run(12);
        for (int k = 0; k < 10 && pwm_out[1] !== 1'b1; k++) tick();
        check("ch1_high_before_reset", 32'(pwm_out[1]), 32'd1);
        #3;
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check("midreset_pwm", 32'(pwm_out), 32'd0);
        check("midreset_wrap", 32'(wrap_pulse), 32'd0);
        check("midreset_mix", 32'(mix_out), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        run_count(20, 1, h, w);
        check("ch1_after_reset_highs", 32'(h), 32'd0);
        check("ch1_after_reset_wraps", 32'(w), 32'd0);
        write_ch(1, 7, 3);
        run(3);
        run_count(14, 1, h, w);
        check("ch1_rewrite_highs", 32'(h), 32'd6);
        check("ch1_rewrite_wraps", 32'(w), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
